// File: rtl/mysystem_pio_pkg.sv
// Shared constants for the mysystem PIO/GPIO peripheral: register offsets
// and edge-capture mode encodings.
package mysystem_pio_pkg;

    // Word offsets on the Avalon-MM slave
    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_DIR     = 3'd1;
    localparam logic [2:0] REG_IRQMASK = 3'd2;
    localparam logic [2:0] REG_EDGE    = 3'd3;
    localparam logic [2:0] REG_OUTSET  = 3'd4;
    localparam logic [2:0] REG_OUTCLR  = 3'd5;

    // Edge-capture modes
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/mysystem_pio_gpio_if.sv
// Avalon-MM slave bus bundle for the GPIO peripheral (no wait states).
interface mysystem_pio_gpio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata
    );
endinterface

// File: rtl/mysystem_pio_sync_edge.sv
// Input synchroniser, previous-sample stage and edge pulse generation.
// in_sync lags in_port by SYNC_STAGES clocks; edge_pulse is combinational
// from in_sync vs in_prev, so the capture register one level up sees the
// edge SYNC_STAGES+1 clocks after the pin changed.
module mysystem_pio_sync_edge
    import mysystem_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  in_prev;

    assign in_sync = sync_q[SYNC_STAGES-1];

    // Shift the pins through the synchroniser and keep one older sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            in_prev <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
            in_prev <= in_sync;
        end
    end

    // Select which transition produces a capture pulse
    always_comb begin
        edge_pulse = in_sync & ~in_prev;
        case (EDGE_TYPE)
            EDGE_FALL: edge_pulse = ~in_sync & in_prev;
            EDGE_ANY:  edge_pulse = in_sync ^ in_prev;
            default:   edge_pulse = in_sync & ~in_prev;
        endcase
    end

endmodule

// File: rtl/mysystem_pio_gpio.sv
// Parametrised bidirectional GPIO on Avalon-MM: per-bit direction, atomic
// set/clear, synchronised inputs, sticky edge capture and a maskable,
// registered level interrupt.
module mysystem_pio_gpio
    import mysystem_pio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_OUT   = '0,
    parameter logic [31:0] RESET_DIR   = '0,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    mysystem_pio_gpio_if.slave  bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic [WIDTH-1:0]    out_port,
    output logic [WIDTH-1:0]    oe_port,
    output logic                irq
);

    logic             wr, rd;
    logic [WIDTH-1:0] wdata, in_sync, edge_pulse, edge_clr;
    logic [WIDTH-1:0] irq_mask, edge_cap;
    logic [31:0]      rd_mux, readdata_q;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign rd       = bus.chipselect & ~bus.read_n;
    assign wdata    = bus.writedata[WIDTH-1:0];
    assign edge_clr = (wr && bus.address == REG_EDGE) ? wdata : '0;
    assign bus.readdata = readdata_q;

    mysystem_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .in_sync    (in_sync),
        .edge_pulse (edge_pulse)
    );

    // Writable control registers; reserved offsets fall through untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port <= RESET_OUT[WIDTH-1:0];
            oe_port  <= RESET_DIR[WIDTH-1:0];
            irq_mask <= '0;
        end else if (wr) begin
            case (bus.address)
                REG_DATA:    out_port <= wdata;
                REG_DIR:     oe_port  <= wdata;
                REG_IRQMASK: irq_mask <= wdata;
                REG_OUTSET:  out_port <= out_port | wdata;
                REG_OUTCLR:  out_port <= out_port & ~wdata;
                default:     ;
            endcase
        end
    end

    // Sticky capture with W1C; a new edge overrides a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            edge_cap <= (edge_cap & ~edge_clr) | edge_pulse;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    // Read mux; bits above WIDTH and write-only/reserved offsets read 0
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            REG_DATA:    rd_mux[WIDTH-1:0] = (oe_port & out_port) | (~oe_port & in_sync);
            REG_DIR:     rd_mux[WIDTH-1:0] = oe_port;
            REG_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
            REG_EDGE:    rd_mux[WIDTH-1:0] = edge_cap;
            default:     rd_mux = '0;
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   readdata_q <= '0;
        else if (rd) readdata_q <= rd_mux;
    end

endmodule

// File: tb/tb_mysystem_pio_gpio.sv
// Self-checking bench for mysystem_pio_gpio: directed table, multi-cycle
// edge/irq sequences, a WIDTH=8 instance and a randomized phase against a
// cycle-level reference model of the register map.
module tb_mysystem_pio_gpio;
    import mysystem_pio_pkg::*;

    logic        clk = 1'b0, reset = 1'b0, run = 1'b0;
    logic [31:0] in32 = '0, out32, oe32;
    logic        irq32, irq8;
    logic [7:0]  in8 = '0, out8, oe8;
    int          n_cmp = 0, n_bad = 0;

    mysystem_pio_gpio_if bif32();
    mysystem_pio_gpio_if bif8();

    mysystem_pio_gpio #(
        .WIDTH(32), .RESET_OUT(32'hA5), .RESET_DIR(32'hFF),
        .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2)
    ) dut32 (
        .clk(clk), .reset(reset), .bus(bif32.slave),
        .in_port(in32), .out_port(out32), .oe_port(oe32), .irq(irq32)
    );

    mysystem_pio_gpio #(
        .WIDTH(8), .RESET_OUT(32'h0), .RESET_DIR(32'h0),
        .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(3)
    ) dut8 (
        .clk(clk), .reset(reset), .bus(bif8.slave),
        .in_port(in8), .out_port(out8), .oe_port(oe8), .irq(irq8)
    );

    always #5 if (run) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bif32.chipselect = 1'b0; bif32.write_n = 1'b1; bif32.read_n = 1'b1;
        bif8.chipselect  = 1'b0; bif8.write_n  = 1'b1; bif8.read_n  = 1'b1;
    endtask

    task automatic bus_wr(input bit s8, input logic [2:0] a, input logic [31:0] d);
        if (s8) begin
            bif8.address = a; bif8.writedata = d; bif8.chipselect = 1'b1; bif8.write_n = 1'b0;
        end else begin
            bif32.address = a; bif32.writedata = d; bif32.chipselect = 1'b1; bif32.write_n = 1'b0;
        end
        tick();
        bus_idle();
    endtask

    task automatic bus_rd(input bit s8, input logic [2:0] a, output logic [31:0] d);
        if (s8) begin
            bif8.address = a; bif8.chipselect = 1'b1; bif8.read_n = 1'b0;
        end else begin
            bif32.address = a; bif32.chipselect = 1'b1; bif32.read_n = 1'b0;
        end
        tick();
        bus_idle();
        d = s8 ? bif8.readdata : bif32.readdata;
    endtask

    // Reference model state for the randomized phase (32-bit instance).
    // ph[k] holds the pin value sampled k+1 clock edges ago.
    logic [31:0] m_out, m_dir, m_mask, m_cap, m_rd;
    logic        m_irq;
    logic [31:0] ph [3];

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            REG_DATA:    return (m_dir & m_out) | (~m_dir & ph[1]);
            REG_DIR:     return m_dir;
            REG_IRQMASK: return m_mask;
            REG_EDGE:    return m_cap;
            default:     return 32'h0;
        endcase
    endfunction

    typedef struct {
        bit          is_wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;   // write: expected out_port, read: expected readdata
        string       name;
    } vec_t;

    vec_t        tbl [$];
    logic [31:0] rdv;

    initial begin
        bif32.address = '0; bif32.writedata = '0;
        bif8.address  = '0; bif8.writedata  = '0;
        bus_idle();

        tbl.push_back('{1'b1, REG_DATA,    32'h0000_00F0, 32'h0000_00F0, "wr_data"});
        tbl.push_back('{1'b1, REG_OUTSET,  32'h0000_000F, 32'h0000_00FF, "wr_outset"});
        tbl.push_back('{1'b1, REG_OUTCLR,  32'h0000_0030, 32'h0000_00CF, "wr_outclr"});
        tbl.push_back('{1'b0, REG_OUTSET,  32'h0,         32'h0,         "rd_outset"});
        tbl.push_back('{1'b0, REG_OUTCLR,  32'h0,         32'h0,         "rd_outclr"});
        tbl.push_back('{1'b0, REG_DATA,    32'h0,         32'h0000_00CF, "rd_data_dirff"});
        tbl.push_back('{1'b1, REG_DIR,     32'h0000_FFFF, 32'h0000_00CF, "wr_dir"});
        tbl.push_back('{1'b0, REG_DIR,     32'h0,         32'h0000_FFFF, "rd_dir"});
        tbl.push_back('{1'b1, REG_IRQMASK, 32'h0000_0005, 32'h0000_00CF, "wr_mask"});
        tbl.push_back('{1'b0, REG_IRQMASK, 32'h0,         32'h0000_0005, "rd_mask"});
        tbl.push_back('{1'b1, 3'd6,        32'hFFFF_FFFF, 32'h0000_00CF, "wr_rsv6"});
        tbl.push_back('{1'b1, 3'd7,        32'h0000_0000, 32'h0000_00CF, "wr_rsv7"});
        tbl.push_back('{1'b0, 3'd6,        32'h0,         32'h0,         "rd_rsv6"});
        tbl.push_back('{1'b0, 3'd7,        32'h0,         32'h0,         "rd_rsv7"});

        // Asynchronous reset with the clock stopped
        #2 reset = 1'b1;
        #1;
        chk("rst_out32",  out32, 32'hA5);
        chk("rst_oe32",   oe32,  32'hFF);
        chk("rst_irq32",  {31'b0, irq32}, 32'h0);
        chk("rst_rd32",   bif32.readdata, 32'h0);
        chk("rst_out8",   {24'b0, out8}, 32'h0);
        chk("rst_rd8",    bif8.readdata, 32'h0);
        #2 reset = 1'b0;
        #2 run = 1'b1;
        tick(4);

        // Table-driven register accesses
        foreach (tbl[i]) begin
            if (tbl[i].is_wr) begin
                bus_wr(1'b0, tbl[i].addr, tbl[i].data);
                chk(tbl[i].name, out32, tbl[i].exp);
            end else begin
                bus_rd(1'b0, tbl[i].addr, rdv);
                chk(tbl[i].name, rdv, tbl[i].exp);
            end
        end
        chk("oe_after_tbl", oe32, 32'h0000_FFFF);

        // Mixed direction read
        bus_wr(1'b0, REG_DATA, 32'h1234_5678);
        in32 = 32'hABCD_0000;
        tick(3);
        bus_rd(1'b0, REG_DATA, rdv);
        chk("mixed_dir_data", rdv, 32'hABCD_5678);

        // Return pins low and clear everything captured so far
        in32 = 32'h0;
        tick(4);
        bus_wr(1'b0, REG_EDGE, 32'hFFFF_FFFF);
        tick();
        chk("irq_idle", {31'b0, irq32}, 32'h0);
        bus_wr(1'b0, REG_IRQMASK, 32'h1);

        // Rising edge on bit 0: captured on the 3rd clock, irq on the 4th
        in32 = 32'h1;
        tick(2);
        bus_rd(1'b0, REG_EDGE, rdv);
        chk("cap_not_yet", rdv, 32'h0);
        chk("irq_not_yet", {31'b0, irq32}, 32'h0);
        bus_rd(1'b0, REG_EDGE, rdv);
        chk("cap_bit0", rdv, 32'h1);
        chk("irq_set", {31'b0, irq32}, 32'h1);
        bus_wr(1'b0, REG_EDGE, 32'h1);
        chk("irq_hold_w1c", {31'b0, irq32}, 32'h1);
        tick();
        chk("irq_drop_w1c", {31'b0, irq32}, 32'h0);

        // Unmasking an already captured bit
        in32 = 32'h3;
        tick(4);
        chk("irq_masked", {31'b0, irq32}, 32'h0);
        bus_wr(1'b0, REG_IRQMASK, 32'h3);
        chk("irq_unmask_edge", {31'b0, irq32}, 32'h0);
        tick();
        chk("irq_unmask", {31'b0, irq32}, 32'h1);
        bus_wr(1'b0, REG_IRQMASK, 32'h1);
        bus_wr(1'b0, REG_EDGE, 32'h2);

        // W1C in the same cycle the bit-3 edge is captured: edge wins
        in32 = 32'hB;
        tick(2);
        bus_wr(1'b0, REG_EDGE, 32'h8);
        bus_rd(1'b0, REG_EDGE, rdv);
        chk("collision_bit3", rdv, 32'h8);
        bus_wr(1'b0, REG_EDGE, 32'h8);

        // Falling edge is ignored in rising mode
        in32 = 32'h3;
        tick(5);
        bus_rd(1'b0, REG_EDGE, rdv);
        chk("fall_ignored", rdv, 32'h0);

        // WIDTH=8 instance: truncation, upper bits, reserved offsets
        bus_wr(1'b1, REG_DATA, 32'hFFFF_FF3C);
        chk("w8_out", {24'b0, out8}, 32'h3C);
        bus_wr(1'b1, REG_DIR, 32'hFFFF_FFFF);
        chk("w8_oe", {24'b0, oe8}, 32'hFF);
        bus_rd(1'b1, REG_DATA, rdv);
        chk("w8_rd_data", rdv, 32'h0000_003C);
        bus_rd(1'b1, REG_DIR, rdv);
        chk("w8_rd_dir", rdv, 32'h0000_00FF);
        bus_wr(1'b1, 3'd6, 32'hFFFF_FFFF);
        bus_wr(1'b1, 3'd7, 32'h0000_0000);
        chk("w8_rsv_out", {24'b0, out8}, 32'h3C);
        chk("w8_rsv_oe",  {24'b0, oe8},  32'hFF);
        bus_rd(1'b1, REG_IRQMASK, rdv);
        chk("w8_rsv_mask", rdv, 32'h0);
        bus_rd(1'b1, 3'd6, rdv);
        chk("w8_rd6", rdv, 32'h0);
        bus_rd(1'b1, 3'd7, rdv);
        chk("w8_rd7", rdv, 32'h0);

        // WIDTH=8 instance captures both edges in any-edge mode
        in8 = 8'h01;
        tick(5);
        bus_rd(1'b1, REG_EDGE, rdv);
        chk("w8_any_rise", rdv, 32'h1);
        bus_wr(1'b1, REG_EDGE, 32'h1);
        in8 = 8'h00;
        tick(6);
        bus_rd(1'b1, REG_EDGE, rdv);
        chk("w8_any_fall", rdv, 32'h1);

        // Randomized phase: establish a known state, then free-run
        m_out  = $urandom();
        m_dir  = $urandom();
        m_mask = $urandom();
        bus_wr(1'b0, REG_DATA, m_out);
        bus_wr(1'b0, REG_DIR, m_dir);
        bus_wr(1'b0, REG_IRQMASK, m_mask);
        bus_wr(1'b0, REG_EDGE, 32'hFFFF_FFFF);
        tick();
        m_cap = '0;
        m_irq = 1'b0;
        m_rd  = bif32.readdata;
        for (int k = 0; k < 3; k++) ph[k] = in32;

        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [2:0]  a;
            logic [31:0] d, clr, new_cap;
            op = $urandom_range(0, 2);
            a  = 3'($urandom_range(0, 7));
            d  = $urandom();
            if ($urandom_range(0, 2) == 0) in32 = in32 ^ ($urandom() & $urandom());

            // Expected next state from the register map rules
            clr     = (op == 1 && a == REG_EDGE) ? d : 32'h0;
            new_cap = (m_cap & ~clr) | (ph[1] & ~ph[2]);
            m_irq   = |(m_cap & m_mask);
            if (op == 2) m_rd = m_read(a);
            if (op == 1) begin
                case (a)
                    REG_DATA:    m_out  = d;
                    REG_DIR:     m_dir  = d;
                    REG_IRQMASK: m_mask = d;
                    REG_OUTSET:  m_out  = m_out | d;
                    REG_OUTCLR:  m_out  = m_out & ~d;
                    default:     ;
                endcase
            end
            m_cap = new_cap;

            bif32.address    = a;
            bif32.writedata  = d;
            bif32.chipselect = (op != 0);
            bif32.write_n    = (op != 1);
            bif32.read_n     = (op != 2);
            tick();
            bus_idle();
            ph[2] = ph[1];
            ph[1] = ph[0];
            ph[0] = in32;

            chk("rnd_out", out32, m_out);
            chk("rnd_oe", oe32, m_dir);
            chk("rnd_irq", {31'b0, irq32}, {31'b0, m_irq});
            chk("rnd_rd", bif32.readdata, m_rd);
        end

        // Reset asserted mid-operation clears without a clock edge
        #3 reset = 1'b1;
        #1;
        chk("midrst_out", out32, 32'hA5);
        chk("midrst_oe", oe32, 32'hFF);
        chk("midrst_irq", {31'b0, irq32}, 32'h0);
        chk("midrst_rd", bif32.readdata, 32'h0);
        chk("midrst_out8", {24'b0, out8}, 32'h0);
        reset = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
